mult_arbiter: RTL

Round-robin arbiter and sequencer that shares one shift-add multiplier among NUM_REQ requesters. It accepts one operand pair at a time over valid/ready and drives the multiplier start/ready/done protocol. It never issues start while the multiplier is not ready, so it produces no NOT_READY events. It returns the product tagged with the requester id, and a watchdog aborts operations whose done never arrives.

---
 rtl/mult_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one start/ready/done multiplier among NUM_REQ requesters.
// Returns each product tagged with its requester id; a watchdog aborts operations whose done never arrives.
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0]      req_multiplicand_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_multiplier_i,
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id_o,
    output logic [2*WIDTH-1:0]            resp_product_o,
    output logic                          resp_err_o,
    input  logic                          mul_ready_i,
    output logic                          mul_start_o,
    output logic [WIDTH-1:0]              mul_multiplicand_o,
    output logic [WIDTH-1:0]              mul_multiplier_o,
    input  logic [2*WIDTH-1:0]            mul_product_i,
    input  logic                          mul_done_i,
    output logic                          busy_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [WIDTH-1:0]    mcand_r;
    logic [WIDTH-1:0]    mplier_r;
    logic [ID_W-1:0]     id_r;
    logic                resp_valid_r;
    logic [ID_W-1:0]     resp_id_r;
    logic [2*WIDTH-1:0]  resp_product_r;
    logic                resp_err_r;

    logic                found_s;
    logic [ID_W-1:0]     winner_s;
    logic [NUM_REQ-1:0]  req_ready_s;

    // Winner search: first valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        int idx_v;
        idx_v    = 0;
        found_s  = 1'b0;
        winner_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v = (int'(rr_ptr_r) + k) % NUM_REQ;
            if (!found_s && req_valid_i[idx_v]) begin
                found_s  = 1'b1;
                winner_s = ID_W'(idx_v);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Accept strobe goes to the winner only while idle.
    always_comb begin
        req_ready_s = '0;
        if (state_r == IDLE && found_s) begin
            req_ready_s[winner_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Sequencer: accept, issue start when the multiplier is ready, wait with watchdog, respond.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r        <= IDLE;
            rr_ptr_r       <= '0;
            cnt_r          <= '0;
            mcand_r        <= '0;
            mplier_r       <= '0;
            id_r           <= '0;
            resp_valid_r   <= 1'b0;
            resp_id_r      <= '0;
            resp_product_r <= '0;
            resp_err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        mcand_r  <= req_multiplicand_i[winner_s*WIDTH +: WIDTH];
                        mplier_r <= req_multiplier_i[winner_s*WIDTH +: WIDTH];
                        id_r     <= winner_s;
                        state_r  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mul_ready_i) begin
                        cnt_r   <= '0;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    // done takes priority over a watchdog expiry in the same cycle
                    if (mul_done_i) begin
                        resp_product_r <= mul_product_i;
                        resp_err_r     <= 1'b0;
                        resp_id_r      <= id_r;
                        resp_valid_r   <= 1'b1;
                        state_r        <= RESP;
                    end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                        resp_product_r <= '0;
                        resp_err_r     <= 1'b1;
                        resp_id_r      <= id_r;
                        resp_valid_r   <= 1'b1;
                        state_r        <= RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_r <= 1'b0;
                        rr_ptr_r     <= (id_r == ID_W'(NUM_REQ - 1)) ? ID_W'(0) : id_r + ID_W'(1);
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o        = req_ready_s;
    assign mul_start_o        = (state_r == ISSUE) && mul_ready_i;
    assign mul_multiplicand_o = mcand_r;
    assign mul_multiplier_o   = mplier_r;
    assign resp_valid_o       = resp_valid_r;
    assign resp_id_o          = resp_id_r;
    assign resp_product_o     = resp_product_r;
    assign resp_err_o         = resp_err_r;
    assign busy_o             = (state_r != IDLE);

endmodule
